// File: rtl/ips2l_rsp_gen_32bit_pkg.sv
// ips2l_rsp_gen_32bit_pkg: UART-control shared definitions (response FSM states, header bytes).
// Rev 1.0
`default_nettype none

package ips2l_rsp_gen_32bit_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    HDR   = 4'd1,
    ADDRL = 4'd2,
    ADDRM = 4'd3,
    ADDRH = 4'd4,
    DB0   = 4'd5,
    DB1   = 4'd6,
    DB2   = 4'd7,
    DB3   = 4'd8
  } rsp_state_t;

  localparam logic [7:0] C_HDR_RD = 8'h72;  // 'r'
  localparam logic [7:0] C_HDR_WR = 8'h77;  // 'w'

endpackage

`default_nettype wire

// File: rtl/ips2l_rsp_gen_32bit.sv
// ips2l_rsp_gen_32bit: serialises a read/write response into UART TX FIFO bytes.
// Rev 1.0
`default_nettype none

module ips2l_rsp_gen_32bit #(
  parameter int ECHO_ADDR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic        rsp_is_rd,
  input  logic [23:0] rsp_addr,
  input  logic [31:0] rsp_data,
  input  logic        tx_fifo_full,
  output logic        tx_fifo_wr,
  output logic [7:0]  tx_fifo_wdata,
  output logic [15:0] frame_cnt
);
  import ips2l_rsp_gen_32bit_pkg::*;

  rsp_state_t  r_state;
  rsp_state_t  w_next;
  logic        r_is_rd;
  logic [23:0] r_addr;
  logic [31:0] r_data;
  logic [15:0] r_frame_cnt;
  logic        w_hs;
  logic        w_frame_done;

  assign w_hs      = rsp_valid & rsp_ready;
  assign frame_cnt = r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_is_rd     <= 1'b0;
      r_addr      <= 24'd0;
      r_data      <= 32'd0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_is_rd <= rsp_is_rd;
        r_addr  <= rsp_addr;
        r_data  <= rsp_data;
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Strobe is combinational on ~tx_fifo_full; state only moves when a byte is actually written.
  always_comb begin
    w_next        = r_state;
    rsp_ready     = 1'b0;
    tx_fifo_wr    = 1'b0;
    tx_fifo_wdata = 8'h00;
    w_frame_done  = 1'b0;
    case (r_state)
      IDLE: begin
        rsp_ready = 1'b1;
        if (rsp_valid) w_next = HDR;
      end
      HDR: begin
        tx_fifo_wr    = ~tx_fifo_full;
        tx_fifo_wdata = r_is_rd ? C_HDR_RD : C_HDR_WR;
        if (tx_fifo_wr) begin
          if (ECHO_ADDR != 0) begin
            w_next = ADDRL;
          end else if (r_is_rd) begin
            w_next = DB0;
          end else begin
            w_next       = IDLE;
            w_frame_done = 1'b1;
          end
        end
      end
      ADDRL: begin
        tx_fifo_wr    = ~tx_fifo_full;
        tx_fifo_wdata = r_addr[7:0];
        if (tx_fifo_wr) w_next = ADDRM;
      end
      ADDRM: begin
        tx_fifo_wr    = ~tx_fifo_full;
        tx_fifo_wdata = r_addr[15:8];
        if (tx_fifo_wr) w_next = ADDRH;
      end
      ADDRH: begin
        tx_fifo_wr    = ~tx_fifo_full;
        tx_fifo_wdata = r_addr[23:16];
        if (tx_fifo_wr) begin
          if (r_is_rd) begin
            w_next = DB0;
          end else begin
            w_next       = IDLE;
            w_frame_done = 1'b1;
          end
        end
      end
      DB0: begin
        tx_fifo_wr    = ~tx_fifo_full;
        tx_fifo_wdata = r_data[7:0];
        if (tx_fifo_wr) w_next = DB1;
      end
      DB1: begin
        tx_fifo_wr    = ~tx_fifo_full;
        tx_fifo_wdata = r_data[15:8];
        if (tx_fifo_wr) w_next = DB2;
      end
      DB2: begin
        tx_fifo_wr    = ~tx_fifo_full;
        tx_fifo_wdata = r_data[23:16];
        if (tx_fifo_wr) w_next = DB3;
      end
      DB3: begin
        tx_fifo_wr    = ~tx_fifo_full;
        tx_fifo_wdata = r_data[31:24];
        if (tx_fifo_wr) begin
          w_next       = IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ips2l_rsp_gen_32bit.sv
// tb_ips2l_rsp_gen_32bit: directed self-checking bench for both ECHO_ADDR settings.
// Rev 1.0
`default_nettype none

module tb_ips2l_rsp_gen_32bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v1 = 1'b0, rd1 = 1'b0, full1 = 1'b0;
  logic [23:0] a1 = '0;
  logic [31:0] d1 = '0;
  logic        rdy1, wr1;
  logic [7:0]  wd1;
  logic [15:0] fc1;

  logic        v0 = 1'b0, rd0 = 1'b0, full0 = 1'b0;
  logic [23:0] a0 = '0;
  logic [31:0] d0 = '0;
  logic        rdy0, wr0;
  logic [7:0]  wd0;
  logic [15:0] fc0;

  int total = 0;
  int bad   = 0;
  int wrcnt1 = 0;
  int wrcnt0 = 0;
  int base;

  always #5 clk = ~clk;

  ips2l_rsp_gen_32bit #(.ECHO_ADDR(1)) dut (
    .clk(clk), .rst_n(rst_n), .rsp_valid(v1), .rsp_ready(rdy1), .rsp_is_rd(rd1),
    .rsp_addr(a1), .rsp_data(d1), .tx_fifo_full(full1), .tx_fifo_wr(wr1),
    .tx_fifo_wdata(wd1), .frame_cnt(fc1)
  );

  ips2l_rsp_gen_32bit #(.ECHO_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rsp_valid(v0), .rsp_ready(rdy0), .rsp_is_rd(rd0),
    .rsp_addr(a0), .rsp_data(d0), .tx_fifo_full(full0), .tx_fifo_wr(wr0),
    .tx_fifo_wdata(wd0), .frame_cnt(fc0)
  );

  always @(posedge clk) begin
    if (wr1) wrcnt1 <= wrcnt1 + 1;
    if (wr0) wrcnt0 <= wrcnt0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_rdy(input bit sel);
    return sel ? rdy0 : rdy1;
  endfunction
  function automatic logic o_wr(input bit sel);
    return sel ? wr0 : wr1;
  endfunction
  function automatic logic [7:0] o_wd(input bit sel);
    return sel ? wd0 : wd1;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic rd, input logic [23:0] a,
                       input logic [31:0] d);
    if (sel) begin v0 = v; rd0 = rd; a0 = a; d0 = d; end
    else     begin v1 = v; rd1 = rd; a1 = a; d1 = d; end
  endtask

  task automatic set_full(input bit sel, input logic f);
    if (sel) full0 = f; else full1 = f;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle after the frame.
  task automatic run_frame(input bit sel, input string tag, input logic rd, input logic [23:0] a,
                           input logic [31:0] d, input int n, input logic [63:0] exp,
                           input int stall_at, input int stall_len, input bit keep_valid);
    logic [63:0] e;
    e = exp;
    drive(sel, 1'b1, rd, a, d);
    #1;
    chk({tag, ".ready"}, {31'd0, o_rdy(sel)}, 32'd1);
    chk({tag, ".idle_wr"}, {31'd0, o_wr(sel)}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) drive(sel, 1'b0, ~rd, ~a, ~d);
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          set_full(sel, 1'b1);
          #1;
          chk({tag, ".stall_wr"}, {31'd0, o_wr(sel)}, 32'd0);
          chk({tag, ".stall_byte"}, {24'd0, o_wd(sel)}, {24'd0, e[8*k +: 8]});
          @(negedge clk);
        end
        set_full(sel, 1'b0);
      end
      #1;
      chk({tag, ".wr"}, {31'd0, o_wr(sel)}, 32'd1);
      chk({tag, ".byte"}, {24'd0, o_wd(sel)}, {24'd0, e[8*k +: 8]});
      @(negedge clk);
    end
    #1;
    chk({tag, ".end_ready"}, {31'd0, o_rdy(sel)}, 32'd1);
    chk({tag, ".end_wr"}, {31'd0, o_wr(sel)}, 32'd0);
    chk({tag, ".end_byte"}, {24'd0, o_wd(sel)}, 32'd0);
  endtask

  initial begin
    // Reset values while rst_n is low, before any clock edge matters.
    #2;
    chk("rst.ready", {31'd0, rdy1}, 32'd1);
    chk("rst.wr", {31'd0, wr1}, 32'd0);
    chk("rst.byte", {24'd0, wd1}, 32'd0);
    chk("rst.fcnt", {16'd0, fc1}, 32'd0);
    chk("rst.fcnt0", {16'd0, fc0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort during ADDRM, then a clean frame.
    drive(0, 1'b1, 1'b1, 24'h123456, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 24'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("abort.pre_wr", {31'd0, wr1}, 32'd1);
    chk("abort.pre_byte", {24'd0, wd1}, 32'h34);
    rst_n = 1'b0;
    #1;
    chk("abort.wr", {31'd0, wr1}, 32'd0);
    chk("abort.ready", {31'd0, rdy1}, 32'd1);
    chk("abort.byte", {24'd0, wd1}, 32'd0);
    chk("abort.fcnt", {16'd0, fc1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("abort.idle", {31'd0, rdy1}, 32'd1);
    chk("abort.fcnt2", {16'd0, fc1}, 32'd0);
    @(negedge clk);

    base = wrcnt1;
    run_frame(0, "rd1", 1'b1, 24'h123456, 32'hDEADBEEF, 8, 64'hDEADBEEF_12345672, -1, 0, 1'b0);
    chk("rd1.fcnt", {16'd0, fc1}, 32'd1);
    chk("rd1.count", wrcnt1 - base, 32'd8);

    run_frame(0, "wack", 1'b0, 24'h00ABCD, 32'hFFFFFFFF, 4, 64'h00000000_00ABCD77, -1, 0, 1'b0);
    chk("wack.fcnt", {16'd0, fc1}, 32'd2);

    base = wrcnt1;
    run_frame(0, "stall", 1'b1, 24'h123456, 32'hDEADBEEF, 8, 64'hDEADBEEF_12345672, 5, 3, 1'b0);
    chk("stall.count", wrcnt1 - base, 32'd8);
    chk("stall.fcnt", {16'd0, fc1}, 32'd3);

    // Wrap: jump the counter to its last value, then complete one more frame.
    dut.r_frame_cnt = 16'hFFFF;
    #1;
    chk("wrap.pre", {16'd0, fc1}, 32'h0000FFFF);
    @(negedge clk);
    run_frame(0, "wrap", 1'b0, 24'hA5A5A5, 32'h0, 4, 64'h00000000_A5A5A577, -1, 0, 1'b0);
    chk("wrap.fcnt", {16'd0, fc1}, 32'd0);

    base = wrcnt1;
    run_frame(0, "b2b_a", 1'b1, 24'h010203, 32'h11223344, 8, 64'h11223344_01020372, -1, 0, 1'b1);
    run_frame(0, "b2b_b", 1'b1, 24'hC0FFEE, 32'hCAFEF00D, 8, 64'hCAFEF00D_C0FFEE72, -1, 0, 1'b0);
    chk("b2b.count", wrcnt1 - base, 32'd16);
    chk("b2b.fcnt", {16'd0, fc1}, 32'd2);

    base = wrcnt0;
    run_frame(1, "e0rd", 1'b1, 24'h777777, 32'h01020304, 5, 64'h00000001_02030472, -1, 0, 1'b0);
    run_frame(1, "e0wr", 1'b0, 24'h777777, 32'h01020304, 1, 64'h00000000_00000077, -1, 0, 1'b0);
    chk("e0.count", wrcnt0 - base, 32'd6);
    chk("e0.fcnt", {16'd0, fc0}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
